// File: rtl/encoder_pulse_gen.sv
// Quadrature encoder emulator: emits PULSE plus A/B quadrature at a programmed period, direction and step count.
// Define INDEX_PULSE_EN to build the position counter that drives the ENC_Z index output.
module encoder_pulse_gen #(
  parameter int PERIOD_WIDTH  = 16,
  parameter int COUNT_WIDTH   = 16,
  parameter int MIN_PERIOD    = 4,
  parameter int STEPS_PER_REV = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOAD,
  input  logic [PERIOD_WIDTH-1:0] PERIOD,
  input  logic [COUNT_WIDTH-1:0]  COUNT,
  input  logic                    DIR,
  input  logic                    STOP,
  output logic                    PULSE,
  output logic                    ENC_A,
  output logic                    ENC_B,
  output logic                    ENC_Z,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [COUNT_WIDTH-1:0]  STEPS_SENT
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] ONE_P = PERIOD_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]  ONE_C = COUNT_WIDTH'(1);

  // A two-cycle minimum PULSE high time needs a period of at least 4.
  if (MIN_PERIOD < 4 || STEPS_PER_REV < 2) begin : g_bad_params
    $error("encoder_pulse_gen: MIN_PERIOD must be >= 4 and STEPS_PER_REV >= 2");
  end

  state_t                  state, state_nxt;
  logic [PERIOD_WIDTH-1:0] period_reg;
  logic [PERIOD_WIDTH-1:0] phase;
  logic [PERIOD_WIDTH-1:0] period_clamped;
  logic [PERIOD_WIDTH-1:0] half_period;
  logic [COUNT_WIDTH-1:0]  count_reg;
  logic                    dir_reg;
  logic                    stop_req;
  logic                    load_ok;
  logic                    boundary;
  logic                    end_run;
  logic                    step_now;

  assign load_ok        = (state == IDLE) && LOAD && !STOP;
  assign period_clamped = (PERIOD < MIN_P) ? MIN_P : PERIOD;
  assign half_period    = period_reg >> 1;

  // phase counts the cycles of the current period; the last one is a step boundary.
  assign boundary = (state == RUN) && (phase == period_reg - ONE_P);
  assign end_run  = boundary &&
                    (stop_req || STOP || ((count_reg != '0) && (STEPS_SENT == count_reg)));
  assign step_now = boundary && !end_run;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_ok) state_nxt = RUN;
      RUN:     if (end_run) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      period_reg <= '0;
      phase      <= '0;
      count_reg  <= '0;
      dir_reg    <= 1'b0;
      stop_req   <= 1'b0;
      PULSE      <= 1'b0;
      ENC_A      <= 1'b0;
      ENC_B      <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      STEPS_SENT <= '0;
    end else begin
      DONE <= 1'b0;
      if (load_ok) begin
        period_reg <= period_clamped;
        phase      <= period_clamped - ONE_P;
        count_reg  <= COUNT;
        dir_reg    <= DIR;
        stop_req   <= 1'b0;
        STEPS_SENT <= '0;
      end else if (state == RUN) begin
        BUSY <= 1'b1;
        if (STOP) stop_req <= 1'b1;
        if (end_run) begin
          BUSY     <= 1'b0;
          DONE     <= 1'b1;
          PULSE    <= 1'b0;
          stop_req <= 1'b0;
        end else if (step_now) begin
          phase      <= '0;
          PULSE      <= 1'b1;
          STEPS_SENT <= STEPS_SENT + ONE_C;
          // Gray-code advance: forward 00-10-11-01, reverse 00-01-11-10.
          if (dir_reg) begin
            ENC_A <= ~ENC_B;
            ENC_B <= ENC_A;
          end else begin
            ENC_A <= ENC_B;
            ENC_B <= ~ENC_A;
          end
        end else begin
          phase <= phase + ONE_P;
          PULSE <= (phase + ONE_P) < half_period;
        end
      end
    end
  end

`ifdef INDEX_PULSE_EN
  localparam int POS_W = $clog2(STEPS_PER_REV);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(STEPS_PER_REV - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_nxt;

  always_comb begin
    pos_nxt = pos;
    if (dir_reg) begin
      pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_ONE;
    end else begin
      pos_nxt = (pos == '0) ? POS_LAST : pos - POS_ONE;
    end
  end

  // Index stays high for the whole period of the step that lands on position 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pos   <= '0;
      ENC_Z <= 1'b0;
    end else if (step_now) begin
      pos   <= pos_nxt;
      ENC_Z <= (pos_nxt == '0);
    end else if (end_run) begin
      ENC_Z <= 1'b0;
    end
  end
`else
  assign ENC_Z = 1'b0;
`endif

endmodule
